// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - button front-end and IDLE/RUN/PAUSE controller for the MM.SS timer
// Optional lap snapshot path is built only when STOPWATCH_LAP_EN is defined.

module stopwatch_debounce #(
   parameter int DB_CYCLES = 1000000
) (
   input  logic clk,
   input  logic reset_n,
   input  logic btn,
   output logic press
);
   localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

   logic          sync1_q, sync2_q;
   logic          level_q, level_d;
   logic          level_dly_q;
   logic          press_q;
   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      level_d = level_q;
      cnt_d   = '0;
      if (sync2_q != level_q) begin
         if (cnt_q == CW'(DB_CYCLES - 1)) begin
            level_d = ~level_q;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q     <= 1'b0;
         sync2_q     <= 1'b0;
         level_q     <= 1'b0;
         level_dly_q <= 1'b0;
         press_q     <= 1'b0;
         cnt_q       <= '0;
      end else begin
         sync1_q     <= btn;
         sync2_q     <= sync1_q;
         level_q     <= level_d;
         cnt_q       <= cnt_d;
         level_dly_q <= level_q;
         press_q     <= level_q & ~level_dly_q;
      end
   end

   assign press = press_q;
endmodule

module stopwatch_ctrl #(
   parameter int DB_CYCLES = 1000000
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       btn_ss,
   input  logic       btn_lap,
   input  logic       btn_clr,
   input  logic [3:0] t_d3,
   input  logic [3:0] t_d2,
   input  logic [3:0] t_d1,
   input  logic [3:0] t_d0,
   output logic       go,
   output logic       stop,
   output logic       clr,
   output logic [3:0] disp_d3,
   output logic [3:0] disp_d2,
   output logic [3:0] disp_d1,
   output logic [3:0] disp_d0,
   output logic       running,
   output logic       lap_active
);
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE} state_t;

   state_t      state_q;
   logic        go_q, stop_q, clr_q, running_q;
   logic        press_ss, press_clr;
   logic [15:0] live_digits;

   assign live_digits = {t_d3, t_d2, t_d1, t_d0};

   stopwatch_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_ss (
      .clk(clk), .reset_n(reset_n), .btn(btn_ss), .press(press_ss)
   );
   stopwatch_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_clr (
      .clk(clk), .reset_n(reset_n), .btn(btn_clr), .press(press_clr)
   );

`ifdef STOPWATCH_LAP_EN
   logic        press_lap;
   logic        lap_active_q;
   logic [15:0] lap_q;

   stopwatch_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_lap (
      .clk(clk), .reset_n(reset_n), .btn(btn_lap), .press(press_lap)
   );
`else
   logic unused_btn_lap;
   assign unused_btn_lap = btn_lap;
`endif

   // One winning press per cycle: clr beats ss beats lap, losers are dropped.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= S_IDLE;
         go_q         <= 1'b0;
         stop_q       <= 1'b0;
         clr_q        <= 1'b1;
         running_q    <= 1'b0;
`ifdef STOPWATCH_LAP_EN
         lap_active_q <= 1'b0;
         lap_q        <= '0;
`endif
      end else begin
         go_q   <= 1'b0;
         stop_q <= 1'b0;
         clr_q  <= 1'b0;
         if (press_clr) begin
            case (state_q)
               S_IDLE: clr_q <= 1'b1;
               S_PAUSE: begin
                  state_q      <= S_IDLE;
                  clr_q        <= 1'b1;
`ifdef STOPWATCH_LAP_EN
                  lap_active_q <= 1'b0;
`endif
               end
               default: ;
            endcase
         end else if (press_ss) begin
            case (state_q)
               S_RUN: begin
                  state_q   <= S_PAUSE;
                  stop_q    <= 1'b1;
                  running_q <= 1'b0;
               end
               default: begin
                  state_q   <= S_RUN;
                  go_q      <= 1'b1;
                  running_q <= 1'b1;
               end
            endcase
`ifdef STOPWATCH_LAP_EN
         end else if (press_lap) begin
            case (state_q)
               S_RUN: begin
                  lap_q        <= live_digits;
                  lap_active_q <= 1'b1;
               end
               S_PAUSE: lap_active_q <= 1'b0;
               default: ;
            endcase
`endif
         end
      end
   end

   assign go      = go_q;
   assign stop    = stop_q;
   assign clr     = clr_q;
   assign running = running_q;

`ifdef STOPWATCH_LAP_EN
   assign lap_active = lap_active_q;
   assign {disp_d3, disp_d2, disp_d1, disp_d0} = lap_active_q ? lap_q : live_digits;
`else
   assign lap_active = 1'b0;
   assign {disp_d3, disp_d2, disp_d1, disp_d0} = live_digits;
`endif
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - self-checking bench for stopwatch_ctrl with DB_CYCLES=4
// Expected behaviour follows STOPWATCH_LAP_EN the same way the design does.

module tb_stopwatch_ctrl;
   localparam int DB = 4;
`ifdef STOPWATCH_LAP_EN
   localparam bit LAP_EN = 1'b1;
`else
   localparam bit LAP_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic btn_ss = 1'b0, btn_lap = 1'b0, btn_clr = 1'b0;
   logic [3:0] t_d3 = '0, t_d2 = '0, t_d1 = '0, t_d0 = '0;
   logic go, stop, clr, running, lap_active;
   logic [3:0] disp_d3, disp_d2, disp_d1, disp_d0;

   always #5 clk = ~clk;

   stopwatch_ctrl #(.DB_CYCLES(DB)) dut (
      .clk(clk), .reset_n(reset_n),
      .btn_ss(btn_ss), .btn_lap(btn_lap), .btn_clr(btn_clr),
      .t_d3(t_d3), .t_d2(t_d2), .t_d1(t_d1), .t_d0(t_d0),
      .go(go), .stop(stop), .clr(clr),
      .disp_d3(disp_d3), .disp_d2(disp_d2), .disp_d1(disp_d1), .disp_d0(disp_d0),
      .running(running), .lap_active(lap_active)
   );

   int checks = 0, failures = 0;
   int edge_n = 0, go_edge = -1;
   int n_go = 0, n_stop = 0, n_clr = 0;
   bit rand_td = 1'b0;

   // Reference model: a button level is accepted once the last DB synchronised
   // samples all disagree with the accepted level; press and action follow.
   logic [DB:0] hist [3];
   logic        db_m [3];
   logic        rise_m [3];
   logic        press_m [3];
   int          st_m;          // 0 idle, 1 run, 2 pause
   logic        go_m, stop_m, clr_m, lap_m;
   logic [15:0] lapreg_m;

   function automatic logic all_differ(input logic [DB:0] h, input logic d);
      for (int i = 1; i <= DB; i++) if (h[i] == d) return 1'b0;
      return 1'b1;
   endfunction

   task automatic model_reset();
      for (int j = 0; j < 3; j++) begin
         hist[j] = '0; db_m[j] = 1'b0; rise_m[j] = 1'b0; press_m[j] = 1'b0;
      end
      st_m = 0; go_m = 1'b0; stop_m = 1'b0; clr_m = 1'b1; lap_m = 1'b0; lapreg_m = '0;
   endtask

   task automatic model_edge(input logic [2:0] b, input logic [15:0] td);
      go_m = 1'b0; stop_m = 1'b0; clr_m = 1'b0;
      if (press_m[2]) begin
         if (st_m == 0) clr_m = 1'b1;
         else if (st_m == 2) begin st_m = 0; clr_m = 1'b1; lap_m = 1'b0; end
      end else if (press_m[0]) begin
         if (st_m == 1) begin st_m = 2; stop_m = 1'b1; end
         else begin st_m = 1; go_m = 1'b1; end
      end else if (press_m[1] && LAP_EN) begin
         if (st_m == 1) begin lapreg_m = td; lap_m = 1'b1; end
         else if (st_m == 2) lap_m = 1'b0;
      end
      for (int j = 0; j < 3; j++) begin
         press_m[j] = rise_m[j];
         rise_m[j] = 1'b0;
         if (all_differ(hist[j], db_m[j])) begin
            db_m[j] = ~db_m[j];
            rise_m[j] = db_m[j];
         end
         hist[j] = {hist[j][DB-1:0], b[j]};
      end
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s edge=%0d got=%0h want=%0h", name, edge_n, got, want);
      end
   endtask

   task automatic cyc();
      logic [2:0]  b;
      logic [15:0] td;
      logic [20:0] exp_v, act_v;
      if (rand_td) {t_d3, t_d2, t_d1, t_d0} = 16'($urandom);
      b  = {btn_clr, btn_lap, btn_ss};
      td = {t_d3, t_d2, t_d1, t_d0};
      @(posedge clk);
      #1;
      if (!reset_n) model_reset();
      else model_edge(b, td);
      edge_n++;
      if (go) begin n_go++; go_edge = edge_n; end
      if (stop) n_stop++;
      if (clr) n_clr++;
      exp_v = {go_m, stop_m, clr_m, st_m == 1, lap_m & LAP_EN,
               (lap_m & LAP_EN) ? lapreg_m : {t_d3, t_d2, t_d1, t_d0}};
      act_v = {go, stop, clr, running, lap_active, disp_d3, disp_d2, disp_d1, disp_d0};
      chk("model_cycle", 32'(act_v), 32'(exp_v));
   endtask

   task automatic set_btns(input logic [2:0] mask);
      btn_ss = mask[0]; btn_lap = mask[1]; btn_clr = mask[2];
   endtask

   task automatic press(input logic [2:0] mask, input int hold);
      n_go = 0; n_stop = 0; n_clr = 0;
      set_btns(mask);
      repeat (hold) cyc();
      set_btns(3'b000);
      repeat (14) cyc();
   endtask

   typedef struct {
      logic [2:0] mask;
      int         hold;
      int         e_go, e_stop, e_clr;
      logic       e_run, e_lap;
   } vec_t;
   vec_t tbl [15];

   initial begin
      int e0;
      int hold_left [3];

      tbl[0]  = '{3'b100, 6, 0, 0, 0, 1'b1, 1'b0};
      tbl[1]  = '{3'b010, 5, 0, 0, 0, 1'b1, 1'b1};
      tbl[2]  = '{3'b001, 4, 0, 1, 0, 1'b0, 1'b1};
      tbl[3]  = '{3'b010, 7, 0, 0, 0, 1'b0, 1'b0};
      tbl[4]  = '{3'b001, 6, 1, 0, 0, 1'b1, 1'b0};
      tbl[5]  = '{3'b010, 4, 0, 0, 0, 1'b1, 1'b1};
      tbl[6]  = '{3'b001, 9, 0, 1, 0, 1'b0, 1'b1};
      tbl[7]  = '{3'b100, 5, 0, 0, 1, 1'b0, 1'b0};
      tbl[8]  = '{3'b010, 6, 0, 0, 0, 1'b0, 1'b0};
      tbl[9]  = '{3'b100, 4, 0, 0, 1, 1'b0, 1'b0};
      tbl[10] = '{3'b001, 3, 0, 0, 0, 1'b0, 1'b0};
      tbl[11] = '{3'b001, 4, 1, 0, 0, 1'b1, 1'b0};
      tbl[12] = '{3'b001, 8, 0, 1, 0, 1'b0, 1'b0};
      tbl[13] = '{3'b001, 5, 1, 0, 0, 1'b1, 1'b0};
      tbl[14] = '{3'b001, 6, 0, 1, 0, 1'b0, 1'b0};

      model_reset();
      reset_n = 1'b0;
      repeat (3) begin
         cyc();
         chk("reset_clr", 32'(clr), 32'd1);
         chk("reset_go_run", 32'({go, stop, running, lap_active}), 32'd0);
      end
      reset_n = 1'b1;
      cyc();
      chk("clr_after_release", 32'(clr), 32'd0);

      // Start latency: go lands 8 edges after the button edge.
      n_go = 0;
      btn_ss = 1'b1;
      e0 = edge_n;
      repeat (12) cyc();
      chk("go_latency", 32'(go_edge - e0), 32'd8);
      chk("go_count", 32'(n_go), 32'd1);
      chk("running_after_go", 32'(running), 32'd1);
      btn_ss = 1'b0;
      repeat (14) cyc();

      rand_td = 1'b1;
      for (int i = 0; i < 15; i++) begin
         press(tbl[i].mask, tbl[i].hold);
         chk($sformatf("tbl%0d_go", i), 32'(n_go), 32'(tbl[i].e_go));
         chk($sformatf("tbl%0d_stop", i), 32'(n_stop), 32'(tbl[i].e_stop));
         chk($sformatf("tbl%0d_clr", i), 32'(n_clr), 32'(tbl[i].e_clr));
         chk($sformatf("tbl%0d_run", i), 32'(running), 32'(tbl[i].e_run));
         chk($sformatf("tbl%0d_lap", i), 32'(lap_active), 32'(tbl[i].e_lap & LAP_EN));
      end

      // In PAUSE: ss and clr together resolve to a clear only.
      press(3'b101, 6);
      chk("prio_go", 32'(n_go), 32'd0);
      chk("prio_clr", 32'(n_clr), 32'd1);
      chk("prio_run", 32'(running), 32'd0);

      // Lap snapshot holds while live digits move on.
      press(3'b001, 5);
      rand_td = 1'b0;
      {t_d3, t_d2, t_d1, t_d0} = 16'h1234;
      press(3'b010, 5);
      {t_d3, t_d2, t_d1, t_d0} = 16'h5555;
      cyc();
      chk("lap_disp", 32'({disp_d3, disp_d2, disp_d1, disp_d0}), LAP_EN ? 32'h1234 : 32'h5555);
      chk("lap_active", 32'(lap_active), 32'(LAP_EN));
      press(3'b001, 5);
      chk("lap_stop", 32'(n_stop), 32'd1);
      chk("lap_disp_paused", 32'({disp_d3, disp_d2, disp_d1, disp_d0}), LAP_EN ? 32'h1234 : 32'h5555);
      press(3'b010, 5);
      chk("lap_release_disp", 32'({disp_d3, disp_d2, disp_d1, disp_d0}), 32'h5555);

      // Bounce: short pulses are rejected, the stable hold yields one go.
      n_go = 0;
      for (int p = 1; p <= 3; p++) begin
         btn_ss = 1'b1; repeat (p) cyc();
         btn_ss = 1'b0; cyc();
      end
      btn_ss = 1'b1;
      e0 = edge_n;
      repeat (20) cyc();
      btn_ss = 1'b0;
      repeat (14) cyc();
      chk("bounce_go_count", 32'(n_go), 32'd1);
      chk("bounce_go_latency", 32'(go_edge - e0), 32'd8);

      // Asynchronous reset in RUN takes effect before any clock edge.
      #2;
      reset_n = 1'b0;
      #1;
      chk("midrun_reset", 32'({running, clr, go, lap_active}), 32'b0100);
      model_reset();
      repeat (2) cyc();
      reset_n = 1'b1;
      cyc();
      chk("midrun_release_clr", 32'(clr), 32'd0);

      rand_td = 1'b1;
      for (int j = 0; j < 3; j++) hold_left[j] = 0;
      for (int n = 0; n < 3000; n++) begin
         logic [2:0] m;
         m = {btn_clr, btn_lap, btn_ss};
         for (int j = 0; j < 3; j++) begin
            if (hold_left[j] == 0) begin
               m[j] = ($urandom_range(0, 2) == 0);
               hold_left[j] = $urandom_range(1, 10);
            end
            hold_left[j]--;
         end
         set_btns(m);
         reset_n = ($urandom_range(0, 999) != 0);
         cyc();
      end
      reset_n = 1'b1;
      set_btns(3'b000);
      repeat (14) cyc();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Front-end controller for the MM.SS stopwatch timer. It takes three raw push-buttons, synchronises and debounces them, and runs an IDLE/RUN/PAUSE state machine. It issues single-cycle `go`/`stop`/`clr` pulses to the timer's control inputs and optionally freezes a lap snapshot of the timer digits for the 4-digit display multiplexer. It sits between the board buttons and the timer's control/digit ports.

## Interface
- `DB_CYCLES`, default 1000000: consecutive stable cycles required to accept a new button level (20 ms at 50 MHz). Legal range ≥ 2.
- `clk`  in  1  system clock, single clock domain.
- `reset_n`  in  1  asynchronous, active-low reset.
- `btn_ss`  in  1  raw start/stop button, active-high, asynchronous to `clk`.
- `btn_lap`  in  1  raw lap button, active-high, asynchronous.
- `btn_clr`  in  1  raw clear button, active-high, asynchronous.
- `t_d3`, `t_d2`, `t_d1`, `t_d0`  in  4 each  live BCD digits from the timer.
- `go`  out  1  one-cycle start pulse to the timer.
- `stop`  out  1  one-cycle stop pulse to the timer.
- `clr`  out  1  clear pulse to the timer.
- `disp_d3`, `disp_d2`, `disp_d1`, `disp_d0`  out  4 each  digits to the display.
- `running`  out  1  high in RUN.
- `lap_active`  out  1  high while the display shows the frozen lap snapshot.

## Operation
- **Button path (per button):**
  - 2-flop synchroniser.
  - Debounce counter of width ceil(log2(DB_CYCLES)). The counter clears whenever the synchronised level equals the debounced level. Otherwise it increments. When it reaches DB_CYCLES-1 with the level still differing, the debounced level flips and the counter clears.
  - A debounced 0→1 transition produces a registered 1-cycle `press` pulse.
  - Releases produce nothing. A held button produces exactly one press.
- **Priority:** presses in the same cycle resolve as clr > ss > lap. Lower-priority presses in that cycle are discarded, not queued.
- **FSM transitions:**
  - IDLE, ss: go to RUN and pulse `go`.
  - IDLE, clr: pulse `clr` and stay in IDLE.
  - IDLE, lap: ignored.
  - RUN, ss: go to PAUSE and pulse `stop`. `lap_active` is unchanged.
  - RUN, lap: capture `t_d3..t_d0` into the lap registers and set `lap_active`=1. Every lap press in RUN recaptures.
  - RUN, clr: ignored. The timer must be paused before it can be cleared.
  - PAUSE, ss: go to RUN and pulse `go`.
  - PAUSE, lap: clear `lap_active`, returning the display to live digits.
  - PAUSE, clr: go to IDLE, pulse `clr`, clear `lap_active`.
- **Display:** `disp_dN` = `lap_active` ? lap register N : `t_dN`. This mux is combinational.
- **`running`:** (state == RUN), registered.

## Timing
- **Reset values while `reset_n`=0:**
  - State is IDLE.
  - `go`=0, `stop`=0, `running`=0, `lap_active`=0.
  - `clr`=1, so the timer is held clear during reset.
  - Lap registers are 0.
  - Debounced levels and counters are 0.
- **Exit from reset:** `clr` falls on the first `clk` edge after `reset_n` rises.
- **Latency:** a raw level held stable from edge k gives:
  - debounced flip at edge k+2+DB_CYCLES;
  - `press` at k+3+DB_CYCLES;
  - `go`/`stop`/`clr`/state/`lap_active` update at k+4+DB_CYCLES.
- **Pulse width:** `go`, `stop` and `clr` (outside reset) are exactly one cycle and mutually exclusive.
- **Bounce:** any glitch shorter than DB_CYCLES cycles resets the counter and produces no press.
- **Lap capture:** samples the `t_d` values present at the capture edge.
- **Reset mid-operation:** asynchronous return to reset values. In-flight presses are lost.

## Configuration
- Macro `STOPWATCH_LAP_EN`.
- **Defined:** the lap path is built as described above (lap debouncer, lap registers, display mux).
- **Undefined:**
  - No lap debouncer or lap registers are built, and `btn_lap` is ignored.
  - `lap_active` is tied to 0 and `disp_dN` = `t_dN`.
  - The FSM is otherwise identical.

## Test plan
All scenarios use DB_CYCLES=4.
1. **Reset and start.** Stimulus: hold `reset_n`=0 for 3 cycles, release, then hold `btn_ss`=1. Required: `clr`=1 during reset and 0 one cycle after release; single `go` pulse exactly 8 cycles after the `btn_ss` edge; `running`=1 on the same edge.
2. **Bounce rejection.** Stimulus: `btn_ss` pulses of 1–3 cycles separated by 1-cycle lows, then a 20-cycle hold. Required: exactly one `go` pulse, 8 cycles after the start of the stable hold.
3. **Lap capture.** In RUN with `t_d`=1,2,3,4, press lap, then change `t_d` to 5,5,5,5. Required: `lap_active`=1 and `disp`=1,2,3,4 after the change. Press ss → `stop` pulse, `disp` still 1,2,3,4. Press lap → `disp`=5,5,5,5.
4. **Clear gating.** Press clr in RUN → no `clr` pulse and the state stays RUN. Press ss then clr → `stop` pulse then `clr` pulse, state IDLE, `lap_active`=0.
5. **Same-cycle priority and mid-run reset.** In PAUSE, press ss and clr on the same cycle → `clr` pulse only, state IDLE, no `go`. Assert `reset_n` mid-RUN → `running`=0 and `clr`=1 immediately.
6. **Lap compiled out.** Without `STOPWATCH_LAP_EN`, press lap in RUN → `lap_active` stays 0 and `disp` tracks `t_d` every cycle.
